// File: rtl/axis_src_frame_rx.sv
// axis_src_frame_rx: receives source pixels from an AXI-Stream slave and frames them
// into SRC_IMG_WIDTH x SRC_IMG_HEIGHT using local row/col counters. It checks the
// SOF (tuser) and EOL (tlast) markers and the tkeep bytes, then buffers the tagged
// pixels in a 2-entry FIFO that feeds the upsampling core over a valid/ready port.
module axis_src_frame_rx #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int AXIS_STRB_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int UPSP_DATA_WIDTH = 32,
  parameter int SRC_IMG_WIDTH   = 1920,
  parameter int SRC_IMG_HEIGHT  = 1080
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       err_clr,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_STRB_WIDTH-1:0] s_axis_tkeep,
  input  logic                       s_axis_tuser,
  input  logic                       s_axis_tlast,
  output logic                       upsp_valid,
  input  logic                       upsp_ready,
  output logic [UPSP_DATA_WIDTH-1:0] upsp_data,
  output logic                       upsp_sof,
  output logic                       upsp_eol,
  output logic                       upsp_eof,
  output logic                       frame_done,
  output logic                       err_sof,
  output logic                       err_eol,
  output logic                       err_keep
);

  // Counters keep at least one bit so that W=1 / H=1 still elaborate.
  localparam int CW = (SRC_IMG_WIDTH  > 1) ? $clog2(SRC_IMG_WIDTH)  : 1;
  localparam int RW = (SRC_IMG_HEIGHT > 1) ? $clog2(SRC_IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(SRC_IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(SRC_IMG_HEIGHT - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t               state;
  logic [CW-1:0]        col;
  logic [RW-1:0]        row;

  logic [UPSP_DATA_WIDTH-1:0] fifo_data [2];
  logic [1:0]           fifo_sof;
  logic [1:0]           fifo_eol;
  logic [1:0]           fifo_eof;
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count;

  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 start;
  logic [CW-1:0]        pos_col;
  logic [RW-1:0]        pos_row;
  logic                 at_eol;
  logic                 at_eof;
  logic                 keep_bad;

  assign s_axis_tready = !rst && (count < 2'd2) && !(state == IDLE && !en);
  assign accept        = s_axis_tvalid && s_axis_tready;

  // An SOF beat always lands at (0,0); in IDLE only SOF beats are kept.
  assign start    = s_axis_tuser;
  assign push     = accept && (state == ACTIVE || start);
  assign pop      = (count != 2'd0) && upsp_ready;
  assign pos_col  = start ? '0 : col;
  assign pos_row  = start ? '0 : row;
  assign at_eol   = (pos_col == COL_LAST);
  assign at_eof   = at_eol && (pos_row == ROW_LAST);
  assign keep_bad = (s_axis_tkeep != '1);

  assign upsp_valid = (count != 2'd0);
  assign upsp_data  = fifo_data[rd_ptr];
  assign upsp_sof   = fifo_sof[rd_ptr];
  assign upsp_eol   = fifo_eol[rd_ptr];
  assign upsp_eof   = fifo_eof[rd_ptr];

  // FIFO storage, occupancy and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_sof     <= '0;
      fifo_eol     <= '0;
      fifo_eof     <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= UPSP_DATA_WIDTH'(s_axis_tdata);
        fifo_sof[wr_ptr]  <= start;
        fifo_eol[wr_ptr]  <= at_eol;
        fifo_eof[wr_ptr]  <= at_eof;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Framing FSM: position counters, frame-done pulse and state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= push && at_eof;
      if (push) begin
        if (at_eof) begin
          col   <= '0;
          row   <= '0;
          state <= IDLE;
        end else if (at_eol) begin
          col   <= '0;
          row   <= pos_row + 1'b1;
          state <= ACTIVE;
        end else begin
          col   <= pos_col + 1'b1;
          row   <= pos_row;
          state <= ACTIVE;
        end
      end
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sof  <= 1'b0;
      err_eol  <= 1'b0;
      err_keep <= 1'b0;
    end else begin
      if (push && state == ACTIVE && start) err_sof <= 1'b1;
      else if (err_clr)                     err_sof <= 1'b0;
      if (push && (s_axis_tlast != at_eol)) err_eol <= 1'b1;
      else if (err_clr)                     err_eol <= 1'b0;
      if (push && keep_bad)                 err_keep <= 1'b1;
      else if (err_clr)                     err_keep <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_src_frame_rx.sv
// Bench for axis_src_frame_rx with a 4x2 frame: a vector table for the clean frame
// plus directed sequences for back-pressure, idle garbage, marker errors and reset.
module tb_axis_src_frame_rx;

  logic        clk = 1'b0;
  logic        rst, en, err_clr;
  logic        s_axis_tvalid, s_axis_tready;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic        s_axis_tuser, s_axis_tlast;
  logic        upsp_valid, upsp_ready;
  logic [31:0] upsp_data;
  logic        upsp_sof, upsp_eol, upsp_eof;
  logic        frame_done, err_sof, err_eol, err_keep;

  axis_src_frame_rx #(
    .AXIS_DATA_WIDTH(32),
    .AXIS_STRB_WIDTH(4),
    .UPSP_DATA_WIDTH(32),
    .SRC_IMG_WIDTH(4),
    .SRC_IMG_HEIGHT(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .err_clr(err_clr),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .upsp_valid(upsp_valid), .upsp_ready(upsp_ready), .upsp_data(upsp_data),
    .upsp_sof(upsp_sof), .upsp_eol(upsp_eol), .upsp_eof(upsp_eof),
    .frame_done(frame_done), .err_sof(err_sof), .err_eol(err_eol), .err_keep(err_keep)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        sof;
    logic        eol;
    logic        eof;
  } pix_t;

  typedef struct {
    logic [31:0] data;
    logic        tuser;
    logic        tlast;
    logic        sof;
    logic        eol;
    logic        eof;
    logic        done;
  } vec_t;

  vec_t vecs [8];
  pix_t got_q [$];
  pix_t exp_q [$];
  int   done_cnt = 0;
  int   total = 0;
  int   passed = 0;

  // Capture every pixel handed to the core, away from the active edge.
  always @(negedge clk) begin
    if (!rst && upsp_valid && upsp_ready)
      got_q.push_back('{d: upsp_data, sof: upsp_sof, eol: upsp_eol, eof: upsp_eof});
    if (!rst && frame_done) done_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    got_q.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  task automatic exp_pix(input logic [31:0] d, input logic sof, input logic eol, input logic eof);
    exp_q.push_back('{d: d, sof: sof, eol: eol, eof: eof});
  endtask

  task automatic exp_frame(input logic [31:0] base);
    for (int i = 0; i < 8; i++)
      exp_pix(base + 32'(i), i == 0, (i % 4) == 3, i == 7);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic u, input logic l, input logic [3:0] k);
    bit ok;
    ok = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tkeep  = k;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        tick();
        ok = 1'b1;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tkeep  = 4'hF;
    if (!ok) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_frame(input logic [31:0] base);
    for (int i = 0; i < 8; i++)
      send_beat(base + 32'(i), i == 0, (i % 4) == 3, 4'hF);
  endtask

  task automatic drain_compare(input string name);
    for (int i = 0; i < 30 && got_q.size() < exp_q.size(); i++) tick();
    tick();
    check({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_pix%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      vecs[i].data  = 32'hA0 + 32'(i);
      vecs[i].tuser = (i == 0);
      vecs[i].tlast = (i == 3) || (i == 7);
      vecs[i].sof   = (i == 0);
      vecs[i].eol   = (i == 3) || (i == 7);
      vecs[i].eof   = (i == 7);
      vecs[i].done  = (i == 7);
    end

    rst = 1'b1; en = 1'b1; err_clr = 1'b0; upsp_ready = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = 4'hF;
    s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    tick(); tick();
    check("rst_tready", 64'(s_axis_tready), 64'd0);
    check("rst_valid", 64'(upsp_valid), 64'd0);
    check("rst_flags", 64'({frame_done, err_sof, err_eol, err_keep}), 64'd0);
    rst = 1'b0;
    #1;
    check("idle_tready", 64'(s_axis_tready), 64'd1);

    // Test 1: clean frame, one beat per cycle, checked one cycle after each accept.
    clear_logs();
    for (int i = 0; i < 8; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = vecs[i].data;
      s_axis_tuser  = vecs[i].tuser;
      s_axis_tlast  = vecs[i].tlast;
      tick();
      check($sformatf("t1_valid%0d", i), 64'(upsp_valid), 64'd1);
      check($sformatf("t1_data%0d", i), 64'(upsp_data), 64'(vecs[i].data));
      check($sformatf("t1_tags%0d", i), 64'({upsp_sof, upsp_eol, upsp_eof, frame_done}),
            64'({vecs[i].sof, vecs[i].eol, vecs[i].eof, vecs[i].done}));
    end
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    tick();
    check("t1_empty", 64'(upsp_valid), 64'd0);
    check("t1_done_low", 64'(frame_done), 64'd0);
    check("t1_done_cnt", 64'(done_cnt), 64'd1);
    check("t1_errs", 64'({err_sof, err_eol, err_keep}), 64'd0);

    // Test 2: core stalls; only two beats fit, then the rest flows.
    clear_logs();
    upsp_ready = 1'b0;
    send_beat(32'hB0, 1'b1, 1'b0, 4'hF);
    send_beat(32'hB1, 1'b0, 1'b0, 4'hF);
    check("t2_full_tready", 64'(s_axis_tready), 64'd0);
    check("t2_head", 64'({upsp_valid, upsp_data}), 64'({1'b1, 32'hB0}));
    repeat (3) tick();
    check("t2_still_full", 64'(s_axis_tready), 64'd0);
    upsp_ready = 1'b1;
    for (int i = 2; i < 8; i++)
      send_beat(32'hB0 + 32'(i), 1'b0, (i % 4) == 3, 4'hF);
    exp_frame(32'hB0);
    drain_compare("t2");

    // Test 3: disabled idle blocks input; enabled idle drops non-SOF beats.
    clear_logs();
    en = 1'b0;
    #1;
    check("t3_en0_tready", 64'(s_axis_tready), 64'd0);
    en = 1'b1;
    #1;
    check("t3_en1_tready", 64'(s_axis_tready), 64'd1);
    for (int i = 0; i < 3; i++) send_beat(32'hEE0 + 32'(i), 1'b0, 1'b0, 4'hF);
    send_frame(32'hC0);
    exp_frame(32'hC0);
    drain_compare("t3");
    check("t3_done_cnt", 64'(done_cnt), 64'd1);

    // Test 4: missing tlast on the first line end.
    clear_logs();
    for (int i = 0; i < 8; i++)
      send_beat(32'hD0 + 32'(i), i == 0, i == 7, 4'hF);
    exp_frame(32'hD0);
    drain_compare("t4");
    check("t4_err_eol", 64'({err_sof, err_eol, err_keep}), 64'b010);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_err_clr", 64'(err_eol), 64'd0);

    // Test 4b: partial tkeep forwarded; set beats a simultaneous clear.
    clear_logs();
    send_beat(32'hF0, 1'b1, 1'b0, 4'hF);
    send_beat(32'hF1, 1'b0, 1'b0, 4'hF);
    err_clr = 1'b1;
    send_beat(32'hF2, 1'b0, 1'b0, 4'h3);
    err_clr = 1'b0;
    for (int i = 3; i < 8; i++)
      send_beat(32'hF0 + 32'(i), 1'b0, (i % 4) == 3, 4'hF);
    exp_frame(32'hF0);
    drain_compare("t4b");
    check("t4b_errs", 64'({err_sof, err_eol, err_keep}), 64'b001);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Test 5: unexpected SOF at row1 col1 restarts the frame.
    clear_logs();
    send_beat(32'h100, 1'b1, 1'b0, 4'hF);
    send_beat(32'h101, 1'b0, 1'b0, 4'hF);
    send_beat(32'h102, 1'b0, 1'b0, 4'hF);
    send_beat(32'h103, 1'b0, 1'b1, 4'hF);
    send_beat(32'h104, 1'b0, 1'b0, 4'hF);
    send_beat(32'h200, 1'b1, 1'b0, 4'hF);
    check("t5_err_sof", 64'(err_sof), 64'd1);
    for (int i = 1; i < 8; i++)
      send_beat(32'h200 + 32'(i), 1'b0, (i % 4) == 3, 4'hF);
    exp_pix(32'h100, 1'b1, 1'b0, 1'b0);
    exp_pix(32'h101, 1'b0, 1'b0, 1'b0);
    exp_pix(32'h102, 1'b0, 1'b0, 1'b0);
    exp_pix(32'h103, 1'b0, 1'b1, 1'b0);
    exp_pix(32'h104, 1'b0, 1'b0, 1'b0);
    exp_frame(32'h200);
    drain_compare("t5");
    check("t5_done_cnt", 64'(done_cnt), 64'd1);
    check("t5_other_errs", 64'({err_eol, err_keep}), 64'd0);

    // Test 6: reset with two pixels queued mid-frame.
    clear_logs();
    upsp_ready = 1'b0;
    send_beat(32'h300, 1'b1, 1'b0, 4'hF);
    send_beat(32'h301, 1'b0, 1'b0, 4'hF);
    check("t6_queued", 64'(upsp_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_tready", 64'(s_axis_tready), 64'd0);
    tick();
    check("t6_rst_valid", 64'(upsp_valid), 64'd0);
    check("t6_rst_tready2", 64'(s_axis_tready), 64'd0);
    rst = 1'b0;
    upsp_ready = 1'b1;
    clear_logs();
    send_frame(32'h400);
    exp_frame(32'h400);
    drain_compare("t6");
    check("t6_done_cnt", 64'(done_cnt), 64'd1);
    check("t6_errs", 64'({err_sof, err_eol, err_keep}), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
